// File: rtl/debounce_pkg.sv
// Shared types for the debounce_edge conditioning stage.
// Optional event counter in debounce_edge is enabled by DEBOUNCE_EDGE_COUNT_EN.
`timescale 1ns/100ps

package debounce_pkg;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_COUNT  = 1'b1
    } state_e;

    localparam int EVT_CNT_W = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
`timescale 1ns/100ps

module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic sync1_q;
    logic s_q;

    // NOTE: state updates use non-blocking assignments so both flops sample
    // pre-edge values and form a true two-stage pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            s_q     <= 1'b0;
        end else begin
            sync1_q <= d;
            s_q     <= sync1_q;
        end
    end

    assign q = s_q;

endmodule

// File: rtl/debounce_edge.sv
// Debouncer: synchronizes d_in, accepts a new level after STABLE_CYCLES steady
// clocks, and emits one-cycle rise/fall pulses. Macro DEBOUNCE_EDGE_COUNT_EN adds evt_cnt.
`timescale 1ns/100ps

module debounce_edge
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 8,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 d_in,
    output logic                 q,
    output logic                 rise,
    output logic                 fall,
    output logic                 busy
`ifdef DEBOUNCE_EDGE_COUNT_EN
    ,
    output logic [EVT_CNT_W-1:0] evt_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_q, q_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             take;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (d_in),
        .q     (s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            q_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // With a one-cycle window the first differing sample qualifies at once.
    always_comb begin
        take = (s != q_q) &&
               (((state_q == ST_STABLE) && (STABLE_CYCLES == 1)) ||
                ((state_q == ST_COUNT)  && (cnt_q == CNT_LAST)));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STABLE: if ((s != q_q) && (STABLE_CYCLES > 1)) state_d = ST_COUNT;
            ST_COUNT:  if ((s == q_q) || take)                 state_d = ST_STABLE;
            default:   state_d = ST_STABLE;
        endcase
    end

    // NOTE: every signal gets a default before the conditionals, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        cnt_d  = '0;
        q_d    = q_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (take) begin
            q_d    = s;
            rise_d = s;
            fall_d = ~s;
        end else if (s != q_q) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign q    = q_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = (cnt_q != '0);

`ifdef DEBOUNCE_EDGE_COUNT_EN
    logic [EVT_CNT_W-1:0] evt_cnt_q, evt_cnt_d;

    always_comb begin
        evt_cnt_d = evt_cnt_q + EVT_CNT_W'(rise_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_cnt_q <= '0;
        end else begin
            evt_cnt_q <= evt_cnt_d;
        end
    end

    assign evt_cnt = evt_cnt_q;
`endif

endmodule

// File: tb/tb_debounce_edge.sv
// Self-checking bench for debounce_edge (STABLE_CYCLES=4, 6 ns clock) against a
// sliding-window reference model; counter checks run when DEBOUNCE_EDGE_COUNT_EN is defined.
`timescale 1ns/100ps

module tb_debounce_edge;
    import debounce_pkg::*;

    localparam int SC = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic d_in  = 1'b0;
    logic q, rise, fall, busy;
`ifdef DEBOUNCE_EDGE_COUNT_EN
    logic [EVT_CNT_W-1:0] evt_cnt;
`endif

    debounce_edge #(.STABLE_CYCLES(SC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .d_in  (d_in),
        .q     (q),
        .rise  (rise),
        .fall  (fall),
        .busy  (busy)
`ifdef DEBOUNCE_EDGE_COUNT_EN
        ,
        .evt_cnt (evt_cnt)
`endif
    );

    always #3 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Reference: the level seen by the qualifier is d_in delayed two edges; q adopts
    // it once the last SC seen samples all disagree with q.
    logic          m_sync1, m_s, m_q, m_rise, m_fall, m_busy;
    logic [SC-1:0] m_win;
    logic [7:0]    m_evt;

    function automatic logic window_differs(input logic [SC-1:0] w, input logic qv);
        return w == {SC{~qv}};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sync1 <= 1'b0;
            m_s     <= 1'b0;
            m_win   <= '0;
            m_q     <= 1'b0;
            m_rise  <= 1'b0;
            m_fall  <= 1'b0;
            m_busy  <= 1'b0;
            m_evt   <= '0;
        end else begin
            m_sync1 <= d_in;
            m_s     <= m_sync1;
            m_win   <= {m_win[SC-2:0], m_s};
            if (window_differs({m_win[SC-2:0], m_s}, m_q)) begin
                m_q    <= m_s;
                m_rise <= m_s;
                m_fall <= ~m_s;
                m_busy <= 1'b0;
                m_evt  <= m_evt + {7'd0, m_s};
            end else begin
                m_rise <= 1'b0;
                m_fall <= 1'b0;
                m_busy <= (m_s != m_q);
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int rises, falls, busy_hi, q_edge, cap, total_rises;
    logic q_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        rises   = 0;
        falls   = 0;
        busy_hi = 0;
        q_edge  = -1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check("q", q, m_q);
        check("rise", rise, m_rise);
        check("fall", fall, m_fall);
        check("busy", busy, m_busy);
`ifdef DEBOUNCE_EDGE_COUNT_EN
        check("evt_cnt", evt_cnt, m_evt);
`endif
        if (rise === 1'b1) begin
            rises++;
            total_rises++;
        end
        if (fall === 1'b1) falls++;
        if (busy === 1'b1) busy_hi++;
        if (q !== q_last) begin
            q_edge = edge_cnt;
            q_last = q;
        end
    endtask

    task automatic drive(input logic v);
        @(negedge clk);
        d_in = v;
        cap  = edge_cnt + 1;
        clear_counts();
    endtask

    initial begin
        total_rises = 0;
        q_last      = 1'b0;
        clear_counts();

        // Reset held with d_in high
        rst_n = 1'b0;
        d_in  = 1'b1;
        #20;
        check("rst_q", q, 0);
        check("rst_rise", rise, 0);
        check("rst_fall", fall, 0);
        check("rst_busy", busy, 0);
`ifdef DEBOUNCE_EDGE_COUNT_EN
        check("rst_evt", evt_cnt, 0);
`endif

        // Release: q rises on the 6th edge after release
        @(negedge clk);
        rst_n = 1'b1;
        cap   = edge_cnt + 1;
        clear_counts();
        repeat (10) step();
        check("rel_q_edge", q_edge, cap + 5);
        check("rel_rises", rises, 1);
        check("rel_q", q, 1);

        // Return low, then clean 0->1 and 1->0 toggles
        drive(1'b0);
        repeat (10) step();
        check("low_q", q, 0);
        drive(1'b1);
        repeat (20) step();
        check("tog_rise_edge", q_edge, cap + 5);
        check("tog_rises", rises, 1);
        check("tog_q1", q, 1);
        drive(1'b0);
        repeat (20) step();
        check("tog_fall_edge", q_edge, cap + 5);
        check("tog_falls", falls, 1);
        check("tog_q0", q, 0);

        // Glitch of three captured cycles is rejected
        drive(1'b1);
        repeat (3) step();
        @(negedge clk);
        d_in = 1'b0;
        repeat (12) step();
        check("glitch_busy_cycles", busy_hi, 3);
        check("glitch_rises", rises, 0);
        check("glitch_q", q, 0);
        check("glitch_q_edge", q_edge, -1);

        // Bounce: 5 ns toggles off the clock grid for 60 ns, then steady high
        @(negedge clk);
        clear_counts();
        fork
            begin
                #0.5;
                repeat (12) begin
                    d_in = ~d_in;
                    #5;
                end
                d_in = 1'b1;
                cap  = edge_cnt + 1;
            end
            begin
                repeat (10) step();
            end
        join
        repeat (12) step();
        check("bounce_rises", rises, 1);
        check("bounce_q_edge", q_edge, cap + 5);
        check("bounce_q", q, 1);

        // Reset while cnt == 2 clears outputs before the next edge
        drive(1'b0);
        repeat (4) step();
        check("mid_busy_before", busy, 1);
        #0.5;
        rst_n = 1'b0;
        #0.5;
        check("mid_rst_q", q, 0);
        check("mid_rst_rise", rise, 0);
        check("mid_rst_fall", fall, 0);
        check("mid_rst_busy", busy, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        q_last = 1'b0;
        clear_counts();
        repeat (12) step();
        check("mid_no_fall", falls, 0);
        check("mid_no_rise", rises, 0);
        check("mid_q_after", q, 0);
        drive(1'b1);
        repeat (10) step();
        check("mid_requal_edge", q_edge, cap + 5);
        check("mid_requal_rises", rises, 1);

        // Randomized hold lengths against the model
        repeat (60) begin
            drive(1'($urandom_range(0, 1)));
            repeat ($urandom_range(1, 8)) step();
        end

`ifdef DEBOUNCE_EDGE_COUNT_EN
        // 300 qualified rising events from a fresh reset
        @(negedge clk);
        d_in  = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n       = 1'b1;
        q_last      = 1'b0;
        total_rises = 0;
        for (int i = 0; i < 300; i++) begin
            drive(1'b1);
            repeat (7) step();
            drive(1'b0);
            repeat (7) step();
        end
        check("evt_total_rises", total_rises, 300);
        check("evt_300", evt_cnt, 44);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
